// File: rtl/mem_arbiter_2p.sv
// Two-requester round-robin arbiter in front of an 8x16 memory with registered reads.
// Write occupies 3 cycles (IDLE sample, ISSUE, DONE), read occupies 4 (extra RDWAIT).
module mem_arbiter_2p (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_a,
   input  logic        req_b,
   input  logic        wr_a,
   input  logic        wr_b,
   input  logic [2:0]  addr_a,
   input  logic [2:0]  addr_b,
   input  logic [15:0] wdata_a,
   input  logic [15:0] wdata_b,
   output logic        gnt_a,
   output logic        gnt_b,
   output logic        done_a,
   output logic        done_b,
   output logic [15:0] rdata,
   output logic        busy,
   output logic        mem_we,
   output logic        mem_re,
   output logic [2:0]  mem_wr_addr,
   output logic [2:0]  mem_rd_addr,
   output logic [15:0] mem_din,
   input  logic [15:0] mem_dout
);

   typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, DONE} state_t;

   state_t      state_q, state_d;
   logic        prio_q, prio_d;   // 0 = A holds priority, 1 = B
   logic        win_q, win_d;     // 0 = A owns the transaction, 1 = B
   logic        wr_q, wr_d;
   logic [2:0]  addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] rdata_q, rdata_d;
   logic        gnt_a_q, gnt_a_d;
   logic        gnt_b_q, gnt_b_d;
   logic        done_a_q, done_a_d;
   logic        done_b_q, done_b_d;
   logic        busy_q, busy_d;
   logic        mem_we_q, mem_we_d;
   logic        mem_re_q, mem_re_d;
   logic        pick_b;

   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      win_d   = win_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      pick_b  = req_b & (~req_a | prio_q);

      case (state_q)
         IDLE: begin
            if (req_a | req_b) begin
               win_d   = pick_b;
               wr_d    = pick_b ? wr_b    : wr_a;
               addr_d  = pick_b ? addr_b  : addr_a;
               wdata_d = pick_b ? wdata_b : wdata_a;
               state_d = ISSUE;
            end
         end
         ISSUE:  state_d = wr_q ? DONE : RDWAIT;
         RDWAIT: begin
            rdata_d = mem_dout;
            state_d = DONE;
         end
         DONE: begin
            prio_d  = ~win_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered, so they are decoded from the state being entered.
      gnt_a_d  = (state_d != IDLE) && !win_d;
      gnt_b_d  = (state_d != IDLE) &&  win_d;
      done_a_d = (state_d == DONE) && !win_d;
      done_b_d = (state_d == DONE) &&  win_d;
      busy_d   = (state_d != IDLE);
      mem_we_d = (state_d == ISSUE) &&  wr_d;
      mem_re_d = (state_d == ISSUE) && !wr_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         prio_q   <= 1'b0;
         win_q    <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= 3'd0;
         wdata_q  <= 16'd0;
         rdata_q  <= 16'd0;
         gnt_a_q  <= 1'b0;
         gnt_b_q  <= 1'b0;
         done_a_q <= 1'b0;
         done_b_q <= 1'b0;
         busy_q   <= 1'b0;
         mem_we_q <= 1'b0;
         mem_re_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         prio_q   <= prio_d;
         win_q    <= win_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         gnt_a_q  <= gnt_a_d;
         gnt_b_q  <= gnt_b_d;
         done_a_q <= done_a_d;
         done_b_q <= done_b_d;
         busy_q   <= busy_d;
         mem_we_q <= mem_we_d;
         mem_re_q <= mem_re_d;
      end
   end

   assign gnt_a       = gnt_a_q;
   assign gnt_b       = gnt_b_q;
   assign done_a      = done_a_q;
   assign done_b      = done_b_q;
   assign busy        = busy_q;
   assign mem_we      = mem_we_q;
   assign mem_re      = mem_re_q;
   assign rdata       = rdata_q;
   assign mem_wr_addr = addr_q;
   assign mem_rd_addr = addr_q;
   assign mem_din     = wdata_q;

endmodule
